// File: rtl/serial_link_axi2obi_rsp.sv
// AXI4 subordinate replaying each beat of one in-flight AXI burst as a single
// outstanding OBI manager access; WRAP bursts and sizes above 32 bits get SLVERR.
package serial_link_axi2obi_rsp_pkg;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_rsp_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module serial_link_axi2obi_rsp
    import serial_link_axi2obi_rsp_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  axi_req_i,
    output axi_rsp_t  axi_rsp_o,
    output obi_req_t  obi_req_o,
    input  obi_resp_t obi_rsp_i
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RD_REQ   = 4'd1;
    localparam logic [3:0] S_RD_WAIT  = 4'd2;
    localparam logic [3:0] S_RD_RESP  = 4'd3;
    localparam logic [3:0] S_WR_DATA  = 4'd4;
    localparam logic [3:0] S_WR_REQ   = 4'd5;
    localparam logic [3:0] S_WR_WAIT  = 4'd6;
    localparam logic [3:0] S_WR_RESP  = 4'd7;
    localparam logic [3:0] S_RD_ERR   = 4'd8;
    localparam logic [3:0] S_WR_DRAIN = 4'd9;

    logic [3:0]  r_state;
    logic        r_last_was_write;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_beat;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_obi_req;
    logic        r_obi_we;
    logic [3:0]  r_obi_be;
    logic [31:0] r_obi_addr;
    logic [31:0] r_obi_wdata;

    logic        w_idle;
    logic        w_pick_aw;
    logic        w_pick_ar;
    axi_ax_t     w_ax;
    logic        w_ax_bad;
    logic        w_last_beat;
    logic [31:0] w_addr_next;
    logic        w_r_valid;
    logic        w_unused_wlast;

    // W.last carries no sequencing information here; the latched len decides.
    assign w_unused_wlast = axi_req_i.w.last;

    // Round-robin between AW and AR when both are pending in the same IDLE cycle.
    assign w_idle      = (r_state == S_IDLE);
    assign w_pick_aw   = w_idle && axi_req_i.aw_valid && (!axi_req_i.ar_valid || !r_last_was_write);
    assign w_pick_ar   = w_idle && axi_req_i.ar_valid && (!axi_req_i.aw_valid || r_last_was_write);
    assign w_ax        = w_pick_aw ? axi_req_i.aw : axi_req_i.ar;
    assign w_ax_bad    = (w_ax.burst == AXI_BURST_WRAP) || (w_ax.size > 3'd2);
    assign w_last_beat = (r_beat == r_len);
    assign w_addr_next = (r_burst == AXI_BURST_FIXED) ? r_addr : r_addr + (32'd1 << r_size);
    assign w_r_valid   = (r_state == S_RD_RESP) || (r_state == S_RD_ERR);

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = w_pick_aw;
        axi_rsp_o.ar_ready = w_pick_ar;
        axi_rsp_o.w_ready  = (r_state == S_WR_DATA) || (r_state == S_WR_DRAIN);
        axi_rsp_o.b_valid  = (r_state == S_WR_RESP);
        axi_rsp_o.b.id     = r_id;
        axi_rsp_o.b.resp   = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_rsp_o.r_valid  = w_r_valid;
        axi_rsp_o.r.id     = r_id;
        axi_rsp_o.r.data   = (r_state == S_RD_RESP) ? r_rdata : 32'd0;
        axi_rsp_o.r.resp   = (r_state == S_RD_ERR) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_rsp_o.r.last   = w_r_valid && w_last_beat;
    end

    assign obi_req_o.req   = r_obi_req;
    assign obi_req_o.we    = r_obi_we;
    assign obi_req_o.be    = r_obi_be;
    assign obi_req_o.addr  = r_obi_addr;
    assign obi_req_o.wdata = r_obi_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_last_was_write <= 1'b0;
            r_id             <= '0;
            r_addr           <= '0;
            r_len            <= '0;
            r_size           <= '0;
            r_burst          <= '0;
            r_beat           <= '0;
            r_err            <= 1'b0;
            r_rdata          <= '0;
            r_obi_req        <= 1'b0;
            r_obi_we         <= 1'b0;
            r_obi_be         <= '0;
            r_obi_addr       <= '0;
            r_obi_wdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_aw || w_pick_ar) begin
                        r_id             <= w_ax.id;
                        r_addr           <= w_ax.addr;
                        r_len            <= w_ax.len;
                        r_size           <= w_ax.size;
                        r_burst          <= w_ax.burst;
                        r_beat           <= '0;
                        r_err            <= w_ax_bad;
                        r_last_was_write <= w_pick_aw;
                        if (w_pick_aw) begin
                            r_state <= w_ax_bad ? S_WR_DRAIN : S_WR_DATA;
                        end else if (w_ax_bad) begin
                            r_state <= S_RD_ERR;
                        end else begin
                            r_state    <= S_RD_REQ;
                            r_obi_req  <= 1'b1;
                            r_obi_we   <= 1'b0;
                            r_obi_be   <= 4'hF;
                            r_obi_addr <= {w_ax.addr[31:2], 2'b00};
                        end
                    end
                end
                S_RD_REQ: begin
                    if (obi_rsp_i.gnt) begin
                        r_obi_req <= 1'b0;
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        r_rdata <= obi_rsp_i.rdata;
                        r_state <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (axi_req_i.r_ready) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr     <= w_addr_next;
                            r_beat     <= r_beat + 8'd1;
                            r_state    <= S_RD_REQ;
                            r_obi_req  <= 1'b1;
                            r_obi_addr <= {w_addr_next[31:2], 2'b00};
                        end
                    end
                end
                S_WR_DATA: begin
                    if (axi_req_i.w_valid) begin
                        r_obi_req   <= 1'b1;
                        r_obi_we    <= 1'b1;
                        r_obi_be    <= axi_req_i.w.strb;
                        r_obi_wdata <= axi_req_i.w.data;
                        r_obi_addr  <= {r_addr[31:2], 2'b00};
                        r_state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (obi_rsp_i.gnt) begin
                        r_obi_req <= 1'b0;
                        r_state   <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        if (w_last_beat) begin
                            r_state <= S_WR_RESP;
                        end else begin
                            r_addr  <= w_addr_next;
                            r_beat  <= r_beat + 8'd1;
                            r_state <= S_WR_DATA;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (axi_req_i.b_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_ERR: begin
                    if (axi_req_i.r_ready) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                S_WR_DRAIN: begin
                    if (axi_req_i.w_valid) begin
                        if (w_last_beat) begin
                            r_state <= S_WR_RESP;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
